// File: rtl/replace_update_sched.sv
// Update sequencer for the cache replacement-state block: init sweep, refill priority, coalesced hit FIFO.
// Optional statistics outputs (drop_cnt, max_occ) are enabled by defining REPLACE_SCHED_STAT_EN.
module replace_update_sched #(
  parameter int DEPTH      = 256,
  parameter int WAY_NUM    = 4,
  parameter int READ_PORT  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int WAY_WIDTH  = $clog2(WAY_NUM)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [READ_PORT-1:0]            hit_en,
  input  logic [READ_PORT*ADDR_WIDTH-1:0] hit_idx,
  input  logic [READ_PORT*WAY_WIDTH-1:0]  hit_way,
  input  logic                            refill_en,
  input  logic [ADDR_WIDTH-1:0]           refill_idx,
  input  logic [WAY_WIDTH-1:0]            refill_way,
  output logic                            refill_ready,
  input  logic                            reinit,
  output logic                            upd_en,
  output logic                            upd_clear,
  output logic [ADDR_WIDTH-1:0]           upd_idx,
  output logic [WAY_WIDTH-1:0]            upd_way,
  output logic                            init_done
`ifdef REPLACE_SCHED_STAT_EN
  ,
  output logic [15:0]                     drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]     max_occ
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] idx;
    logic [WAY_WIDTH-1:0]  way;
  } entry_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] init_ptr;
  logic                  init_last;

  entry_t                mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count, count_next, avail, n_acc;
  logic                  run_act, pop;
  entry_t                head;
  logic [READ_PORT-1:0]  keep, accept;
  logic [PTR_W-1:0]      slot [READ_PORT];
`ifdef REPLACE_SCHED_STAT_EN
  logic [15:0]           n_drop;
`endif

  assign init_last = (init_ptr == ADDR_WIDTH'(DEPTH - 1));

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_INIT;
    else      state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next   = state;
    refill_ready = 1'b0;
    case (state)
      ST_INIT: if (init_last) state_next = ST_RUN;
      ST_RUN:  refill_ready = 1'b1;
      default: state_next = ST_INIT;
    endcase
    if (reinit) begin
      state_next   = ST_INIT;
      refill_ready = 1'b0;
    end
  end

  assign run_act = (state == ST_RUN) && !reinit;
  assign pop     = run_act && !refill_en && (count != '0);
  assign head    = mem[rd_ptr];
  assign avail   = CNT_W'(FIFO_DEPTH) - count + CNT_W'(pop);

  // Coalesce duplicates against enabled lower ports, then grant free slots in port order.
  always_comb begin
    keep   = '0;
    accept = '0;
    n_acc  = '0;
`ifdef REPLACE_SCHED_STAT_EN
    n_drop = '0;
`endif
    for (int p = 0; p < READ_PORT; p++) begin
      slot[p] = wr_ptr + PTR_W'(n_acc);
      keep[p] = hit_en[p];
      for (int q = 0; q < p; q++) begin
        if (hit_en[q] &&
            hit_idx[q*ADDR_WIDTH +: ADDR_WIDTH] == hit_idx[p*ADDR_WIDTH +: ADDR_WIDTH] &&
            hit_way[q*WAY_WIDTH +: WAY_WIDTH] == hit_way[p*WAY_WIDTH +: WAY_WIDTH])
          keep[p] = 1'b0;
      end
      if (run_act && keep[p]) begin
        if (n_acc < avail) begin
          accept[p] = 1'b1;
          n_acc     = n_acc + 1'b1;
        end
`ifdef REPLACE_SCHED_STAT_EN
        else begin
          n_drop = n_drop + 16'd1;
        end
`endif
      end
    end
    count_next = reinit ? '0 : (count - CNT_W'(pop) + n_acc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_ptr  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      upd_en    <= 1'b0;
      upd_clear <= 1'b0;
      upd_idx   <= '0;
      upd_way   <= '0;
      init_done <= 1'b0;
    end else if (reinit) begin
      init_ptr  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      upd_en    <= 1'b0;
      upd_clear <= 1'b0;
      upd_idx   <= '0;
      upd_way   <= '0;
      init_done <= 1'b0;
    end else if (state == ST_INIT) begin
      upd_en    <= 1'b1;
      upd_clear <= 1'b1;
      upd_idx   <= init_ptr;
      upd_way   <= '0;
      init_done <= 1'b0;
      init_ptr  <= init_last ? '0 : init_ptr + 1'b1;
    end else begin
      init_done <= 1'b1;
      upd_clear <= 1'b0;
      rd_ptr    <= rd_ptr + PTR_W'(pop);
      wr_ptr    <= wr_ptr + PTR_W'(n_acc);
      count     <= count_next;
      if (refill_en) begin
        upd_en  <= 1'b1;
        upd_idx <= refill_idx;
        upd_way <= refill_way;
      end else if (pop) begin
        upd_en  <= 1'b1;
        upd_idx <= head.idx;
        upd_way <= head.way;
      end else begin
        upd_en  <= 1'b0;
        upd_idx <= '0;
        upd_way <= '0;
      end
    end
  end

  // NOTE: FIFO storage has no reset; count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    for (int p = 0; p < READ_PORT; p++) begin
      if (accept[p]) begin
        mem[slot[p]] <= '{idx: hit_idx[p*ADDR_WIDTH +: ADDR_WIDTH],
                          way: hit_way[p*WAY_WIDTH +: WAY_WIDTH]};
      end
    end
  end

`ifdef REPLACE_SCHED_STAT_EN
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, drop_cnt} + {1'b0, n_drop};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
      max_occ  <= '0;
    end else if (reinit) begin
      drop_cnt <= '0;
      max_occ  <= '0;
    end else begin
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (count_next > max_occ) max_occ <= count_next;
    end
  end
`endif

endmodule

// File: tb/tb_replace_update_sched.sv
// Self-checking bench for replace_update_sched: queue-based reference model, directed and random steps.
module tb_replace_update_sched;
  localparam int DEPTH = 256;
  localparam int RP    = 2;
  localparam int FD    = 4;
  localparam int AW    = 8;
  localparam int WW    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [RP-1:0]     hit_en;
  logic [RP*AW-1:0]  hit_idx;
  logic [RP*WW-1:0]  hit_way;
  logic              refill_en;
  logic [AW-1:0]     refill_idx;
  logic [WW-1:0]     refill_way;
  logic              refill_ready;
  logic              reinit;
  logic              upd_en, upd_clear, init_done;
  logic [AW-1:0]     upd_idx;
  logic [WW-1:0]     upd_way;
`ifdef REPLACE_SCHED_STAT_EN
  logic [15:0]       drop_cnt;
  logic [2:0]        max_occ;
`endif

  replace_update_sched #(.DEPTH(DEPTH), .WAY_NUM(4), .READ_PORT(RP), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .hit_en(hit_en), .hit_idx(hit_idx), .hit_way(hit_way),
    .refill_en(refill_en), .refill_idx(refill_idx), .refill_way(refill_way),
    .refill_ready(refill_ready), .reinit(reinit), .upd_en(upd_en), .upd_clear(upd_clear),
    .upd_idx(upd_idx), .upd_way(upd_way), .init_done(init_done)
`ifdef REPLACE_SCHED_STAT_EN
    , .drop_cnt(drop_cnt), .max_occ(max_occ)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct { int idx; int way; } ent_t;
  ent_t q[$];
  bit   m_init;
  int   m_ptr, m_drop, m_occ;
  bit   e_en, e_clear, e_done;
  int   e_idx, e_way;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1; m_ptr = 0; q.delete(); m_drop = 0; m_occ = 0;
  endtask

  // One cycle of the specified behaviour, producing the outputs expected after the next edge.
  task automatic model_step();
    ent_t h;
    bit   popped, dup;
    if (reinit) begin
      model_reset();
      e_en = 0; e_clear = 0; e_idx = 0; e_way = 0; e_done = 0;
    end else if (m_init) begin
      e_en = 1; e_clear = 1; e_idx = m_ptr; e_way = 0; e_done = 0;
      m_ptr++;
      if (m_ptr == DEPTH) begin m_init = 0; m_ptr = 0; end
    end else begin
      e_done = 1; e_clear = 0; popped = 0;
      if (!refill_en && q.size() > 0) begin h = q.pop_front(); popped = 1; end
      for (int p = 0; p < RP; p++) begin
        if (hit_en[p]) begin
          dup = 0;
          for (int k = 0; k < p; k++)
            if (hit_en[k] && hit_idx[k*AW +: AW] == hit_idx[p*AW +: AW] &&
                hit_way[k*WW +: WW] == hit_way[p*WW +: WW]) dup = 1;
          if (!dup) begin
            if (q.size() < FD) q.push_back('{idx: int'(hit_idx[p*AW +: AW]), way: int'(hit_way[p*WW +: WW])});
            else if (m_drop < 65535) m_drop++;
          end
        end
      end
      if (refill_en) begin e_en = 1; e_idx = int'(refill_idx); e_way = int'(refill_way); end
      else if (popped) begin e_en = 1; e_idx = h.idx; e_way = h.way; end
      else begin e_en = 0; e_idx = 0; e_way = 0; end
      if (q.size() > m_occ) m_occ = q.size();
    end
  endtask

  // Inputs are driven just before calling; checks run 1 time unit after the edge.
  task automatic tick();
    #1;
    chk("refill_ready", 32'(refill_ready), 32'(!m_init && !reinit));
    model_step();
    @(posedge clk); #1;
    chk("upd_en", 32'(upd_en), 32'(e_en));
    chk("upd_clear", 32'(upd_clear), 32'(e_clear));
    if (e_en) begin
      chk("upd_idx", 32'(upd_idx), 32'(e_idx));
      chk("upd_way", 32'(upd_way), 32'(e_way));
    end
    chk("init_done", 32'(init_done), 32'(e_done));
`ifdef REPLACE_SCHED_STAT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("max_occ", 32'(max_occ), 32'(m_occ));
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"}, 32'(upd_en), 0);
    chk({tag, "_clear"}, 32'(upd_clear), 0);
    chk({tag, "_idx"}, 32'(upd_idx), 0);
    chk({tag, "_way"}, 32'(upd_way), 0);
    chk({tag, "_done"}, 32'(init_done), 0);
    chk({tag, "_ready"}, 32'(refill_ready), 0);
`ifdef REPLACE_SCHED_STAT_EN
    chk({tag, "_drop"}, 32'(drop_cnt), 0);
    chk({tag, "_occ"}, 32'(max_occ), 0);
`endif
  endtask

  task automatic idle();
    hit_en = '0; hit_idx = '0; hit_way = '0;
    refill_en = 0; refill_idx = '0; refill_way = '0; reinit = 0;
  endtask

  task automatic set_hit(input int p, input int idx, input int way);
    hit_en[p] = 1'b1;
    hit_idx[p*AW +: AW] = AW'(idx);
    hit_way[p*WW +: WW] = WW'(way);
  endtask

  task automatic set_refill(input int idx, input int way);
    refill_en = 1; refill_idx = AW'(idx); refill_way = WW'(way);
  endtask

  int drop0;

  initial begin
    idle();
    rst = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    rst = 1;

    // Post-reset sweep of 256 clears, then init_done with no update.
    repeat (DEPTH) tick();
    tick();
    chk("sweep_end_done", 32'(init_done), 1);
    chk("sweep_end_en", 32'(upd_en), 0);

    // Refill wins over a same-cycle hit; the hit follows one cycle later.
    set_hit(0, 5, 2); set_refill(9, 1);
    tick();
    chk("prio_idx", 32'(upd_idx), 9);
    chk("prio_way", 32'(upd_way), 1);
    idle();
    tick();
    chk("hit_idx", 32'(upd_idx), 5);
    chk("hit_way", 32'(upd_way), 2);
    tick();
    chk("drain_empty", 32'(upd_en), 0);

    // Identical hits on both ports coalesce into one update.
    set_hit(0, 7, 3); set_hit(1, 7, 3);
    tick();
    idle();
    tick();
    chk("coal_idx", 32'(upd_idx), 7);
    tick();
    chk("coal_single", 32'(upd_en), 0);

    // Refills every cycle with two hits each: FIFO fills, four hits drop, queue drains in order.
    drop0 = m_drop;
    for (int c = 0; c < 4; c++) begin
      idle();
      set_refill(100 + c, c);
      set_hit(0, 10 + 2*c, c); set_hit(1, 11 + 2*c, 3 - c);
      tick();
    end
    chk("fill_drops", 32'(m_drop - drop0), 4);
`ifdef REPLACE_SCHED_STAT_EN
    chk("fill_drop_cnt", 32'(drop_cnt) - 32'(drop0), 4);
    chk("fill_max_occ", 32'(max_occ), 4);
`endif
    idle();
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("drain_order", 32'(upd_idx), 32'(10 + c));
    end
    tick();

    // Reinit with three entries queued: none of them may come out.
    set_refill(20, 0); set_hit(0, 30, 1); set_hit(1, 31, 2);
    tick();
    idle(); set_refill(21, 1); set_hit(0, 32, 3);
    tick();
    idle(); reinit = 1;
    tick();
    idle();
    repeat (DEPTH + 1) tick();
    repeat (3) tick();

    // Random traffic with frequent collisions on a small address range.
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int p = 0; p < RP; p++)
        if ($urandom_range(0, 99) < 60) set_hit(p, $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 99) < 30) set_refill($urandom_range(0, 255), $urandom_range(0, 3));
      tick();
    end
    idle();
    repeat (6) tick();

    // Reset in the middle of a sweep, at the cycle showing index 100.
    reinit = 1;
    tick();
    idle();
    repeat (101) tick();
    chk("pre_rst_idx", 32'(upd_idx), 100);
    rst = 0;
    #1 chk_zero("mid_rst");
    model_reset();
    repeat (3) begin
      @(posedge clk); #1 chk_zero("held_rst");
    end
    rst = 1;
    repeat (DEPTH + 1) tick();
    chk("final_done", 32'(init_done), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/replace_update_sched.md
Name: replace_update_sched

Overview:
- Sequences all updates into the cache replacement-state block (PLRU or random).
- Merges hit-touch updates from several lookup ports and refill updates onto the single replacement-state update port.
- Runs the post-reset and on-demand state-initialization sweep.
- Sits between the cache tag pipeline and the replacement-state module.

Parameters:
- DEPTH, 256, number of sets.
- WAY_NUM, 4, ways per set.
- READ_PORT, 2, hit-update requesters per cycle.
- FIFO_DEPTH, 4, buffered hit updates (power of 2, ≥2).
- ADDR_WIDTH, log2(DEPTH), set index width.
- WAY_WIDTH, log2(WAY_NUM), way index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- hit_en  in  READ_PORT  per-port hit-touch request.
- hit_idx  in  READ_PORT*ADDR_WIDTH  set index per port; port p at bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- hit_way  in  READ_PORT*WAY_WIDTH  hit way per port.
- refill_en  in  1  refill-touch request.
- refill_idx  in  ADDR_WIDTH  refill set.
- refill_way  in  WAY_WIDTH  refill way.
- refill_ready  out  1  refill accepted this cycle.
- reinit  in  1  pulse: discard pending updates, restart the init sweep.
- upd_en  out  1  update valid to replacement state.
- upd_clear  out  1  write reset state to upd_idx (init sweep only).
- upd_idx  out  ADDR_WIDTH  updated set.
- upd_way  out  WAY_WIDTH  touched way (0 when upd_clear).
- init_done  out  1  sweep complete, updates flowing.

Behaviour:
- FSM states INIT and RUN.
- Reset:
  - state=INIT, init_ptr=0, FIFO empty.
  - All outputs 0: upd_en, upd_clear, upd_idx, upd_way, init_done, refill_ready.
- All upd_* outputs are registered. A decision made in cycle t is visible in cycle t+1.
- INIT state:
  - Each cycle: upd_en=1, upd_clear=1, upd_idx=init_ptr, then init_ptr++.
  - After issuing idx DEPTH-1, move to RUN.
  - In INIT, refill_ready=0; hits are ignored and not counted.
  - First sweep output appears in the cycle after reset deasserts; the sweep takes exactly DEPTH cycles.
  - init_done rises in the cycle after the last clear is issued.
- RUN state:
  - refill_ready=1 combinationally.
  - Each cycle at most one update is issued:
    - refill_en=1: refill issued; FIFO head held.
    - else FIFO non-empty: head popped and issued.
    - else upd_en=0 next cycle.
  - Hit enqueue, all ports evaluated in the same cycle:
    - A port whose (idx,way) equals an enabled lower-numbered port this cycle is coalesced: dropped and not counted.
    - Remaining ports enqueue in ascending port order.
    - Available slots = FIFO_DEPTH − count + (pop this cycle ? 1 : 0).
    - Hits beyond available slots are dropped.
  - Latencies:
    - Refill: issued at t, seen on upd_* at t+1.
    - Hit into an empty FIFO with no refill: enqueued at t, popped at t+1, seen on upd_* at t+2.
  - FIFO pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- reinit:
  - Any state: the next cycle is INIT with init_ptr=0, FIFO flushed, init_done=0.
  - Same-cycle refill/hits are discarded and refill_ready=0 that cycle.
  - reinit during INIT restarts the sweep from 0.
- Reset asserted mid-operation aborts immediately to the reset state. No partial update is issued.

Optional Feature:
- Macro REPLACE_SCHED_STAT_EN.
- When defined:
  - Adds output drop_cnt [15:0]: saturating count of hits dropped for lack of FIFO slots in RUN. Coalesced hits and hits ignored in INIT are not counted.
  - Adds output max_occ [log2(FIFO_DEPTH):0]: peak FIFO count.
  - Both reset to 0 and are cleared by reinit.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, DEPTH=256 → upd_en=upd_clear=1 for 256 consecutive cycles, upd_idx 0..255 in order; init_done=1 on the next cycle; refill_ready=0 throughout the sweep.
- RUN, FIFO empty, cycle t: hit_en=2'b01, idx=5, way=2; refill_en=1, idx=9, way=1 → t+1: upd 9/1; t+2: upd 5/2; t+3: upd_en=0.
- RUN: both ports hit idx=7, way=3 in one cycle → exactly one update 7/3 issued; drop_cnt unchanged.
- RUN: refill every cycle for 4 cycles, 2 distinct hits per cycle (FIFO_DEPTH=4) → FIFO fills after 2 cycles, 4 hits dropped, drop_cnt=4; after refills stop, the 4 queued hits drain in enqueue order.
- RUN, FIFO holding 3 entries, reinit pulse → next 256 cycles are clear sweep 0..255; no queued hit is ever issued; init_done low until the sweep completes.
- rst asserted at sweep idx 100, then released → sweep restarts at idx 0; all outputs 0 while rst is low.
